// File: rtl/simmem_multi_id_message_bank.sv
// Shared-pool message bank keeping a per-ID FIFO as linked lists of entries.
// Optional same-cycle in->out bypass for an empty ID: define SIMMEM_BANK_BYPASS_EN.
module simmem_multi_id_message_bank #(
  parameter int MessageWidth  = 64,
  parameter int TotalCapacity = 32,
  parameter int IDWidth       = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [IDWidth-1:0]                 in_id_i,
  input  logic [MessageWidth-1:0]            in_data_i,
  input  logic [IDWidth-1:0]                 out_id_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [MessageWidth-1:0]            out_data_o,
  output logic [$clog2(TotalCapacity):0]     occupancy_o
);

  localparam int PtrW   = $clog2(TotalCapacity);
  localparam int CntW   = PtrW + 1;
  localparam int NumIds = 2 ** IDWidth;

  logic [MessageWidth-1:0]  data_q  [TotalCapacity];
  logic [PtrW-1:0]          next_q  [TotalCapacity];
  logic [TotalCapacity-1:0] valid_q, valid_d;
  logic [PtrW-1:0]          head_q  [NumIds];
  logic [PtrW-1:0]          head_d  [NumIds];
  logic [PtrW-1:0]          tail_q  [NumIds];
  logic [PtrW-1:0]          tail_d  [NumIds];
  logic [CntW-1:0]          len_q   [NumIds];
  logic [CntW-1:0]          len_d   [NumIds];
  logic [CntW-1:0]          occ_q, occ_d;

  logic [PtrW-1:0] alloc;
  logic            allocFound;
  logic [PtrW-1:0] outHead;
  logic [CntW-1:0] outLen;
  logic [CntW-1:0] inLen;
  logic            storedValid;
  logic            bypass;
  logic            inFire;
  logic            outFire;
  logic            store;
  logic            sameId;
  logic            linkTail;

  // Lowest free entry, from registered valid bits only.
  always_comb begin
    alloc      = '0;
    allocFound = 1'b0;
    for (int i = 0; i < TotalCapacity; i++) begin
      if (!valid_q[i] && !allocFound) begin
        alloc      = PtrW'(i);
        allocFound = 1'b1;
      end
    end
  end

  assign in_ready_o  = ~&valid_q;
  assign outHead     = head_q[out_id_i];
  assign outLen      = len_q[out_id_i];
  assign inLen       = len_q[in_id_i];
  assign storedValid = (outLen != '0);
  assign inFire      = in_valid_i & in_ready_o;
  assign outFire     = storedValid & out_ready_i;

`ifdef SIMMEM_BANK_BYPASS_EN
  // rst_ni gating keeps outputs at their reset values while reset is held.
  assign bypass = rst_ni & inFire & out_ready_i & ~storedValid & (in_id_i == out_id_i);
`else
  assign bypass = 1'b0;
`endif

  assign store       = inFire & ~bypass;
  assign sameId      = outFire & (out_id_i == in_id_i);
  assign linkTail    = store & ~((inLen == '0) || ((inLen == CntW'(1)) && sameId));
  assign out_valid_o = storedValid | bypass;
  assign occupancy_o = occ_q;

  always_comb begin
    out_data_o = '0;
    if (storedValid) begin
      out_data_o = data_q[outHead];
    end else if (bypass) begin
      out_data_o = in_data_i;
    end
  end

  // Release advances the head first; a store into an emptying list then overrides it.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (outFire) begin
      valid_d[outHead]  = 1'b0;
      head_d[out_id_i]  = next_q[outHead];
    end
    if (store) begin
      valid_d[alloc]   = 1'b1;
      tail_d[in_id_i]  = alloc;
      if (!linkTail) begin
        head_d[in_id_i] = alloc;
      end
    end
    for (int i = 0; i < NumIds; i++) begin
      len_d[i] = len_q[i]
               + {{(CntW-1){1'b0}}, (store && (in_id_i == IDWidth'(i)))}
               - {{(CntW-1){1'b0}}, (outFire && (out_id_i == IDWidth'(i)))};
    end
    occ_d = occ_q + {{(CntW-1){1'b0}}, store} - {{(CntW-1){1'b0}}, outFire};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < NumIds; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      len_q   <= len_d;
    end
  end

  // Payload and link storage carry no reset; they are only read behind valid state.
  always_ff @(posedge clk_i) begin
    if (store) begin
      data_q[alloc] <= in_data_i;
    end
    if (linkTail) begin
      next_q[tail_q[in_id_i]] <= alloc;
    end
  end

endmodule
